best_weight_tracker: RTL and testbench

BEST_WEIGHT_TRACKER -- requirements
Module: best_weight_tracker

---
 rtl/best_weight_tracker_pkg.sv | 19 +
 rtl/best_weight_tracker_edge_detect.sv | 21 ++
 rtl/best_weight_tracker.sv | 159 +++++++++++++++
 tb/tb_best_weight_tracker.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/best_weight_tracker_pkg.sv
// Shared training definitions: tracker FSM encoding, address-width derivation
// and the drop counter width.
package best_weight_tracker_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StCopy = 2'd2,
        StHalt = 2'd3
    } tracker_state_e;

    localparam int unsigned DropCntW = 8;

    // A single-entry buffer still needs a one-bit address.
    function automatic int unsigned calc_aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/best_weight_tracker_edge_detect.sv
// edge_detect sub-block: one-cycle pulse on each rising edge of a level input.
module best_weight_tracker_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
        end else begin
            r_level <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level;

endmodule

// File: rtl/best_weight_tracker.sv
// Tracks the lowest iteration error and copies the matching weights from the
// old-weight buffer into the best-weight memory whenever the error improves.
module best_weight_tracker
    import best_weight_tracker_pkg::*;
#(
    parameter int unsigned          NUM_UNKNOWNS = 2,
    parameter int unsigned          W_WIDTH      = 32,
    parameter int unsigned          ERR_WIDTH    = 32,
    parameter logic [ERR_WIDTH-1:0] ERR_THRESH   = '0,
    localparam int unsigned         AW           = calc_aw(NUM_UNKNOWNS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_finished,
    input  logic                 i_stop,
    input  logic [ERR_WIDTH-1:0] i_err_in,
    input  logic                 i_err_valid,
    output logic [AW-1:0]        o_w_rd_addr,
    input  logic [W_WIDTH-1:0]   i_w_rd_data,
    output logic                 o_best_wr_en,
    output logic [AW-1:0]        o_best_wr_addr,
    output logic [W_WIDTH-1:0]   o_best_wr_data,
    output logic                 o_training_done,
    output logic [ERR_WIDTH-1:0] o_best_err,
    output logic                 o_busy,
    output logic [DropCntW-1:0]  o_drop_cnt
);

    // The copy counter runs one past the last read to cover the trailing write.
    localparam int unsigned    CntW    = $clog2(NUM_UNKNOWNS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_UNKNOWNS);
    localparam logic [CntW-1:0] LastRd  = CntW'(NUM_UNKNOWNS - 1);

    tracker_state_e r_state;
    tracker_state_e w_state_next;

    logic                 w_event;
    logic                 w_latch;
    logic                 w_drop;
    logic                 w_rd_active;
    logic                 w_stop_req;
    logic [AW-1:0]        w_rd_addr;

    logic [ERR_WIDTH-1:0] r_err;
    logic [ERR_WIDTH-1:0] r_best_err;
    logic                 r_done;
    logic                 r_stop_pend;
    logic                 r_wr_en;
    logic [AW-1:0]        r_wr_addr;
    logic [CntW-1:0]      r_cnt;
    logic [DropCntW-1:0]  r_drop_cnt;

    best_weight_tracker_edge_detect u_edge_detect (
        .clk     (clk),
        .rst     (rst),
        .i_level (i_finished),
        .o_rise  (w_event)
    );

    assign w_rd_active = (r_state == StCopy) && (r_cnt != LastCnt);
    assign w_rd_addr   = w_rd_active ? r_cnt[AW-1:0] : '0;
    assign w_stop_req  = i_stop | r_stop_pend;

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_stop) begin
                    w_state_next = StHalt;
                end else if (w_event) begin
                    if (i_err_valid) begin
                        w_latch      = 1'b1;
                        w_state_next = StCmp;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            StCmp: begin
                w_drop = w_event;
                if (r_err < r_best_err) begin
                    w_state_next = StCopy;
                end else begin
                    w_state_next = w_stop_req ? StHalt : StIdle;
                end
            end
            StCopy: begin
                w_drop = w_event;
                if (r_cnt == LastCnt) begin
                    w_state_next = w_stop_req ? StHalt : StIdle;
                end
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_err       <= '0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_err <= i_err_in;
            end
            if ((r_state == StCmp) && (r_err <= ERR_THRESH)) begin
                r_done <= 1'b1;
            end
            // A stop seen mid-sequence is remembered until the copy drains.
            if (i_stop && ((r_state == StCmp) || (r_state == StCopy))) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_best_err <= '1;
        end else begin
            r_cnt     <= ((r_state == StCopy) && (r_cnt != LastCnt)) ? r_cnt + 1'b1 : '0;
            r_wr_en   <= w_rd_active;
            r_wr_addr <= w_rd_addr;
            if ((r_state == StCopy) && (r_cnt == LastRd)) begin
                r_best_err <= r_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Buffer data arrives one cycle after its address, aligned with r_wr_en.
    assign o_best_wr_data  = r_wr_en ? i_w_rd_data : '0;
    assign o_best_wr_en    = r_wr_en;
    assign o_best_wr_addr  = r_wr_addr;
    assign o_w_rd_addr     = w_rd_addr;
    assign o_training_done = r_done;
    assign o_best_err      = r_best_err;
    assign o_busy          = (r_state == StCmp) || (r_state == StCopy);
    assign o_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_best_weight_tracker.sv
// Self-checking bench for best_weight_tracker: directed scenarios plus a
// randomized event stream against a transaction-level model.
module tb_best_weight_tracker;

    localparam int unsigned N      = 2;
    localparam int unsigned WW     = 32;
    localparam int unsigned EW     = 32;
    localparam int unsigned AW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [EW-1:0] THRESH = 32'd10;
    localparam logic [EW-1:0] ALL1   = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_finished;
    logic          i_stop;
    logic [EW-1:0] i_err_in;
    logic          i_err_valid;
    logic [AW-1:0] o_w_rd_addr;
    logic [WW-1:0] i_w_rd_data;
    logic          o_best_wr_en;
    logic [AW-1:0] o_best_wr_addr;
    logic [WW-1:0] o_best_wr_data;
    logic          o_training_done;
    logic [EW-1:0] o_best_err;
    logic          o_busy;
    logic [7:0]    o_drop_cnt;

    always #5 clk = ~clk;

    best_weight_tracker #(
        .NUM_UNKNOWNS (N),
        .W_WIDTH      (WW),
        .ERR_WIDTH    (EW),
        .ERR_THRESH   (THRESH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_finished      (i_finished),
        .i_stop          (i_stop),
        .i_err_in        (i_err_in),
        .i_err_valid     (i_err_valid),
        .o_w_rd_addr     (o_w_rd_addr),
        .i_w_rd_data     (i_w_rd_data),
        .o_best_wr_en    (o_best_wr_en),
        .o_best_wr_addr  (o_best_wr_addr),
        .o_best_wr_data  (o_best_wr_data),
        .o_training_done (o_training_done),
        .o_best_err      (o_best_err),
        .o_busy          (o_busy),
        .o_drop_cnt      (o_drop_cnt)
    );

    // Old-weight buffer: registered read port.
    logic [WW-1:0] mem [N];
    always @(posedge clk) i_w_rd_data <= mem[o_w_rd_addr];

    int total = 0;
    int bad   = 0;

    // Transaction-level model state.
    logic [EW-1:0] m_best;
    bit            m_done;
    bit            m_halt;
    int            m_drop;

    // Observations gathered over one run window.
    int            obs_busy;
    int            obs_addr_bad;
    int            obs_done_k;
    int            obs_addr[$];
    logic [WW-1:0] obs_data[$];
    logic [EW-1:0] obs_best_at_last;

    task automatic model_reset();
        m_best = ALL1;
        m_done = 0;
        m_halt = 0;
        m_drop = 0;
    endtask

    task automatic model_event(input logic [EW-1:0] err, input logic valid,
                               output int exp_nwr, output int exp_busy);
        exp_nwr  = 0;
        exp_busy = 0;
        if (m_halt) return;
        if (!valid) begin
            if (m_drop < 255) m_drop++;
            return;
        end
        if (err <= THRESH) m_done = 1;
        if (err < m_best) begin
            m_best   = err;
            exp_nwr  = N;
            exp_busy = N + 2;
        end else begin
            exp_busy = 1;
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_finished = 0;
        i_stop     = 0;
        rst        = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // Drives one event (finished/stop shaped per cycle) and records what the DUT does.
    task automatic run(input logic [EW-1:0] err, input logic valid, input logic [31:0] fin_pat,
                       input logic [31:0] stop_pat, input int ncyc);
        obs_busy         = 0;
        obs_addr_bad     = 0;
        obs_done_k       = -1;
        obs_best_at_last = 'x;
        obs_addr.delete();
        obs_data.delete();
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (o_busy) obs_busy++;
                else if (o_w_rd_addr != 0) obs_addr_bad++;
                if (o_best_wr_en) begin
                    obs_addr.push_back(int'(o_best_wr_addr));
                    obs_data.push_back(o_best_wr_data);
                    obs_best_at_last = o_best_err;
                end
                if (o_training_done && obs_done_k < 0) obs_done_k = k;
            end
            if (k == 0) begin
                i_err_in    = err;
                i_err_valid = valid;
            end
            i_finished = fin_pat[k];
            i_stop     = stop_pat[k];
        end
        i_finished = 0;
    endtask

    task automatic test_reset();
        rst         = 1;
        i_finished  = 0;
        i_stop      = 0;
        i_err_in    = '0;
        i_err_valid = 0;
        fill_mem();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        total += 8;
        if (o_training_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_training_done); end
        if (o_best_err !== ALL1) begin bad++; $display("FAIL reset_best_err got=%h want=%h", o_best_err, ALL1); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        if (o_best_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", o_best_wr_en); end
        if (o_best_wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr got=%0d want=0", o_best_wr_addr); end
        if (o_best_wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got=%h want=0", o_best_wr_data); end
        if (o_w_rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", o_w_rd_addr); end
        if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", o_drop_cnt); end
    endtask

    task automatic test_first_copy();
        int nwr, nbusy;
        fill_mem();
        model_event(32'd100, 1'b1, nwr, nbusy);
        run(32'd100, 1'b1, 32'h3, 32'h0, 7);
        total += 4;
        if (obs_addr.size() != nwr) begin bad++; $display("FAIL s1_nwrites got=%0d want=%0d", obs_addr.size(), nwr); end
        if (obs_busy != nbusy) begin bad++; $display("FAIL s1_busy_cycles got=%0d want=%0d", obs_busy, nbusy); end
        if (obs_best_at_last !== m_best) begin bad++; $display("FAIL s1_best_at_final_write got=%0d want=%0d", obs_best_at_last, m_best); end
        if (obs_addr_bad != 0) begin bad++; $display("FAIL s1_rd_addr_idle got=%0d want=0", obs_addr_bad); end
        for (int i = 0; i < obs_addr.size() && i < N; i++) begin
            total += 2;
            if (obs_addr[i] != i) begin bad++; $display("FAIL s1_wr_addr[%0d] got=%0d want=%0d", i, obs_addr[i], i); end
            if (obs_data[i] !== mem[i]) begin bad++; $display("FAIL s1_wr_data[%0d] got=%h want=%h", i, obs_data[i], mem[i]); end
        end
    endtask

    task automatic test_no_improve();
        int nwr, nbusy;
        logic [EW-1:0] errs [2];
        errs[0] = 32'd100;
        errs[1] = 32'd150;
        for (int j = 0; j < 2; j++) begin
            fill_mem();
            model_event(errs[j], 1'b1, nwr, nbusy);
            run(errs[j], 1'b1, 32'h1, 32'h0, 6);
            total += 3;
            if (obs_addr.size() != nwr) begin bad++; $display("FAIL s2_nwrites err=%0d got=%0d want=%0d", errs[j], obs_addr.size(), nwr); end
            if (obs_busy != nbusy) begin bad++; $display("FAIL s2_busy err=%0d got=%0d want=%0d", errs[j], obs_busy, nbusy); end
            if (o_best_err !== m_best) begin bad++; $display("FAIL s2_best_err got=%0d want=%0d", o_best_err, m_best); end
        end
    endtask

    task automatic test_threshold();
        int nwr, nbusy;
        fill_mem();
        model_event(32'd7, 1'b1, nwr, nbusy);
        run(32'd7, 1'b1, 32'h1, 32'h0, 7);
        total += 4;
        if (obs_done_k != 2) begin bad++; $display("FAIL s3_done_cycle got=%0d want=2", obs_done_k); end
        if (obs_addr.size() != nwr) begin bad++; $display("FAIL s3_nwrites got=%0d want=%0d", obs_addr.size(), nwr); end
        if (o_best_err !== m_best) begin bad++; $display("FAIL s3_best_err got=%0d want=%0d", o_best_err, m_best); end
        if (obs_data.size() == N && obs_data[N-1] !== mem[N-1]) begin
            bad++; $display("FAIL s3_last_data got=%h want=%h", obs_data[N-1], mem[N-1]);
        end
        for (int j = 0; j < 2; j++) begin
            model_event(32'd500, 1'b1, nwr, nbusy);
            run(32'd500, 1'b1, 32'h1, 32'h0, 6);
            total += 2;
            if (o_training_done !== m_done) begin bad++; $display("FAIL s3_done_sticky got=%b want=%b", o_training_done, m_done); end
            if (obs_addr.size() != nwr) begin bad++; $display("FAIL s3_late_writes got=%0d want=%0d", obs_addr.size(), nwr); end
        end
    endtask

    task automatic test_level_and_drop();
        int nwr, nbusy;
        fill_mem();
        model_event(32'd5, 1'b1, nwr, nbusy);
        run(32'd5, 1'b1, 32'h000F_FFFF, 32'h0, 24);
        total += 3;
        if (obs_addr.size() != nwr) begin bad++; $display("FAIL s4_hold_writes got=%0d want=%0d", obs_addr.size(), nwr); end
        if (obs_busy != nbusy) begin bad++; $display("FAIL s4_hold_busy got=%0d want=%0d", obs_busy, nbusy); end
        if (o_drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL s4_hold_drop got=%0d want=%0d", o_drop_cnt, m_drop); end
        // Second rising edge lands while the copy is running.
        fill_mem();
        model_event(32'd3, 1'b1, nwr, nbusy);
        m_drop++;
        run(32'd3, 1'b1, 32'hD, 32'h0, 8);
        total += 4;
        if (o_drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL s4_copy_drop got=%0d want=%0d", o_drop_cnt, m_drop); end
        if (obs_addr.size() != nwr) begin bad++; $display("FAIL s4_copy_writes got=%0d want=%0d", obs_addr.size(), nwr); end
        if (o_best_err !== m_best) begin bad++; $display("FAIL s4_best_err got=%0d want=%0d", o_best_err, m_best); end
        if (obs_busy != nbusy) begin bad++; $display("FAIL s4_copy_busy got=%0d want=%0d", obs_busy, nbusy); end
    endtask

    task automatic test_random();
        int nwr, nbusy, hold, sel;
        logic [EW-1:0] err;
        logic valid;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0) err = m_best;
            else if (sel == 1) err = $urandom_range(0, 12);
            else err = $urandom_range(0, 5000);
            valid = ($urandom_range(0, 3) != 0);
            hold  = $urandom_range(0, 3);
            fill_mem();
            model_event(err, valid, nwr, nbusy);
            run(err, valid, (32'h1 << (hold + 1)) - 32'h1, 32'h0, 8);
            total += 6;
            if (obs_addr.size() != nwr) begin bad++; $display("FAIL rnd_writes it=%0d got=%0d want=%0d", it, obs_addr.size(), nwr); end
            if (obs_busy != nbusy) begin bad++; $display("FAIL rnd_busy it=%0d got=%0d want=%0d", it, obs_busy, nbusy); end
            if (o_best_err !== m_best) begin bad++; $display("FAIL rnd_best it=%0d got=%0d want=%0d", it, o_best_err, m_best); end
            if (o_training_done !== m_done) begin bad++; $display("FAIL rnd_done it=%0d got=%b want=%b", it, o_training_done, m_done); end
            if (o_drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop it=%0d got=%0d want=%0d", it, o_drop_cnt, m_drop); end
            if (obs_addr_bad != 0) begin bad++; $display("FAIL rnd_rd_addr_idle it=%0d got=%0d want=0", it, obs_addr_bad); end
            for (int i = 0; i < obs_addr.size() && i < nwr; i++) begin
                total++;
                if (obs_addr[i] != i || obs_data[i] !== mem[i]) begin
                    bad++;
                    $display("FAIL rnd_wr it=%0d idx=%0d got=%0d/%h want=%0d/%h", it, i, obs_addr[i], obs_data[i], i, mem[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int nwr, nbusy;
        i_err_valid = 0;
        for (int j = 0; j < 260; j++) begin
            @(negedge clk);
            i_finished = 1;
            model_event(32'd0, 1'b0, nwr, nbusy);
            @(negedge clk);
            i_finished = 0;
        end
        @(negedge clk);
        total += 2;
        if (o_drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL sat_drop got=%0d want=%0d", o_drop_cnt, m_drop); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL sat_busy got=%b want=0", o_busy); end
    endtask

    task automatic test_reset_mid_copy();
        bit seen;
        apply_reset();
        fill_mem();
        @(negedge clk);
        i_err_in    = 32'd50;
        i_err_valid = 1;
        i_finished  = 1;
        @(negedge clk);
        i_finished = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = o_best_wr_en;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL s6_first_write got=none want=write within 10 cycles"); end
        #1 rst = 1;
        #1;
        total += 3;
        if (o_best_wr_en !== 1'b0) begin bad++; $display("FAIL s6_wr_en got=%b want=0", o_best_wr_en); end
        if (o_best_err !== ALL1) begin bad++; $display("FAIL s6_best_err got=%h want=%h", o_best_err, ALL1); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL s6_busy got=%b want=0", o_busy); end
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        total += 2;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL s6_idle_after got=%b want=0", o_busy); end
        if (o_best_wr_en !== 1'b0) begin bad++; $display("FAIL s6_wr_after got=%b want=0", o_best_wr_en); end
    endtask

    task automatic test_stop_halt();
        int nwr, nbusy;
        fill_mem();
        model_event(32'd40, 1'b1, nwr, nbusy);
        run(32'd40, 1'b1, 32'h1, 32'hFFFF_FFF8, 7);
        m_halt = 1;
        total += 3;
        if (obs_addr.size() != nwr) begin bad++; $display("FAIL s5_writes got=%0d want=%0d", obs_addr.size(), nwr); end
        if (o_best_err !== m_best) begin bad++; $display("FAIL s5_best_err got=%0d want=%0d", o_best_err, m_best); end
        if (obs_busy != nbusy) begin bad++; $display("FAIL s5_busy got=%0d want=%0d", obs_busy, nbusy); end
        fill_mem();
        model_event(32'd20, 1'b1, nwr, nbusy);
        run(32'd20, 1'b1, 32'h1, 32'hFFFF_FFFF, 6);
        model_event(32'd0, 1'b0, nwr, nbusy);
        run(32'd0, 1'b0, 32'h1, 32'hFFFF_FFFF, 4);
        total += 3;
        if (obs_addr.size() != 0) begin bad++; $display("FAIL s5_halt_writes got=%0d want=0", obs_addr.size()); end
        if (o_drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL s5_halt_drop got=%0d want=%0d", o_drop_cnt, m_drop); end
        if (o_best_err !== m_best) begin bad++; $display("FAIL s5_halt_best got=%0d want=%0d", o_best_err, m_best); end
        // Stop while idle goes straight to halt.
        apply_reset();
        @(negedge clk);
        i_stop = 1;
        @(negedge clk);
        i_stop = 0;
        m_halt = 1;
        fill_mem();
        model_event(32'd30, 1'b1, nwr, nbusy);
        run(32'd30, 1'b1, 32'h1, 32'h0, 6);
        total += 3;
        if (obs_addr.size() != 0) begin bad++; $display("FAIL idle_stop_writes got=%0d want=0", obs_addr.size()); end
        if (o_best_err !== ALL1) begin bad++; $display("FAIL idle_stop_best got=%h want=%h", o_best_err, ALL1); end
        if (obs_busy != 0) begin bad++; $display("FAIL idle_stop_busy got=%0d want=0", obs_busy); end
    endtask

    initial begin
        test_reset();
        test_first_copy();
        test_no_improve();
        test_threshold();
        test_level_and_drop();
        test_random();
        test_saturation();
        test_reset_mid_copy();
        test_stop_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
